// File: rtl/conv_window_feeder.sv
// Raster pixel stream to KxK window issue for the convolution processor.
// Latency: completing pixel accepted at edge N -> mStart (all ones) during cycle N+1.
// Backpressure: pix_ready drops from window issue until cReady returns; one window in flight.
module conv_window_feeder #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                          Clk,
    input  logic                                          Rst_n,
    input  logic                                          pix_valid,
    input  logic [DATA_WIDTH-1:0]                         pix_data,
    output logic                                          pix_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_out,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]            mStart,
    input  logic                                          cReady,
    output logic [15:0]                                   win_count,
    output logic                                          frame_done
);

    localparam int K      = KERNEL_SIZE;
    localparam int VW     = K * K * DATA_WIDTH;
    localparam int SR_LEN = (K - 1) * IMG_WIDTH + K;
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [15:0]             win_count_q, win_count_d;
    logic [VW-1:0]           win_q, win_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   sr_q [SR_LEN];
    logic [DATA_WIDTH-1:0]   sr_d [SR_LEN];

    logic xfer;
    logic completes;

    assign xfer      = (state_q == S_ACCEPT) && pix_valid;
    assign completes = (row_q >= ROW_KM1) && (col_q >= COL_KM1);

    // sr[0] is the newest pixel; sr[d] is the pixel d positions earlier in raster order,
    // so the previous K-1 rows live at multiples of IMG_WIDTH behind it.
    always_comb begin
        sr_d = sr_q;
        if (xfer) begin
            sr_d[0] = pix_data;
            for (int i = 1; i < SR_LEN; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_count_d = win_count_q;
        win_d       = win_q;
        last_d      = last_q;

        unique case (state_q)
            S_IDLE: state_d = S_ACCEPT;
            S_ACCEPT: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (completes) begin
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K; c++) begin
                                win_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] =
                                    sr_d[(K-1-r)*IMG_WIDTH + (K-1-c)];
                            end
                        end
                        last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (cReady) begin
                    win_count_d = win_count_q + 16'd1;
                    state_d     = last_q ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                win_count_d = '0;
                col_d       = '0;
                row_d       = '0;
                state_d     = S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_count_q <= '0;
            win_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_count_q <= win_count_d;
            win_q       <= win_d;
            last_q      <= last_d;
        end
    end

    // Line storage is deliberately not reset; the row counter keeps stale rows out of windows.
    always_ff @(posedge Clk) begin
        sr_q <= sr_d;
    end

    assign pix_ready      = (state_q == S_ACCEPT);
    assign mStart         = (state_q == S_ISSUE) ? '1 : '0;
    assign frame_done     = (state_q == S_DONE);
    assign multiplier_out = win_q;
    assign win_count      = win_count_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized bench for conv_window_feeder: frames of a 4x4 image, K=3, checked against
// windows computed directly from the pixel array.
module tb_conv_window_feeder;

    localparam int DW   = 32;
    localparam int K    = 3;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (H - K + 1) * (W - K + 1);
    localparam int VW   = K * K * DW;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic [DW-1:0]     pix_data = '0;
    logic              pix_ready;
    logic [VW-1:0]     multiplier_out;
    logic [K*K-1:0]    mStart;
    logic              cReady = 1'b0;
    logic [15:0]       win_count;
    logic              frame_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] pix [NPIX];

    conv_window_feeder #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .multiplier_out(multiplier_out),
        .mStart        (mStart),
        .cReady        (cReady),
        .win_count     (win_count),
        .frame_done    (frame_done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Window w in raster order of its top-left corner; element r*K+c = pixel (r0+r, c0+c).
    function automatic logic [VW-1:0] exp_window(input int w);
        int r0;
        int c0;
        logic [VW-1:0] v;
        r0 = w / (W - K + 1);
        c0 = w % (W - K + 1);
        v  = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K+c)*DW +: DW] = pix[(r0 + r) * W + c0 + c];
        return v;
    endfunction

    function automatic bit completes(input int p);
        return ((p / W) >= K - 1) && ((p % W) >= K - 1);
    endfunction

    task automatic fill(input bit rnd, input int base);
        for (int i = 0; i < NPIX; i++)
            pix[i] = rnd ? DW'($urandom) : DW'(base + i);
    endtask

    // Call right after a falling edge: one reset edge, then outputs checked, then release.
    task automatic do_reset();
        Rst_n     = 1'b0;
        cReady    = 1'b0;
        pix_valid = 1'b0;
        @(negedge Clk);
        check("rst_mStart", mStart, '0);
        check("rst_pix_ready", pix_ready, 1'b0);
        check("rst_win_count", win_count, '0);
        check("rst_mult_out", multiplier_out, '0);
        check("rst_frame_done", frame_done, 1'b0);
        Rst_n = 1'b1;
    endtask

    task automatic run_frame(input int dmin, input int dmax, input int pct,
                             input bit spur, input int abort_win);
        int pidx = 0;
        int widx = 0;
        int wcnt = 0;
        int exp_wc = 0;
        int ndone = 0;
        int cyc = 0;
        bit exp_ms = 1'b0;
        bit exp_done = 1'b0;
        bit nxt_ms;
        bit nxt_done;
        logic [K*K-1:0] ms_exp;
        forever begin
            @(negedge Clk);
            cyc++;
            ms_exp = exp_ms ? '1 : '0;
            check("mStart", mStart, ms_exp);
            check("frame_done", frame_done, exp_done);
            check("pix_ready", pix_ready, !(exp_ms || wcnt > 0 || exp_done));
            check("win_count", win_count, exp_wc);
            if (exp_ms)
                check("window", multiplier_out, exp_window(widx));
            else if (wcnt > 0)
                check("held_window", multiplier_out, exp_window(widx - 1));

            nxt_ms    = 1'b0;
            nxt_done  = 1'b0;
            cReady    = 1'b0;
            pix_valid = ($urandom_range(3, 0) == 0);
            pix_data  = $urandom;
            if (exp_done) begin
                ndone++;
                exp_wc = 0;
                if (spur) cReady = 1'b1;
            end else if (exp_ms) begin
                widx++;
                wcnt = $urandom_range(dmax, dmin);
                if (spur) cReady = 1'b1;
            end else if (wcnt > 0) begin
                if (abort_win == widx) begin
                    Rst_n = 1'b0;
                    return;
                end
                wcnt--;
                if (wcnt == 0) begin
                    cReady   = 1'b1;
                    exp_wc++;
                    nxt_done = (widx == NWIN);
                end
            end else begin
                pix_valid = 1'b0;
                if (pidx < NPIX && $urandom_range(99, 0) < pct) begin
                    pix_valid = 1'b1;
                    pix_data  = pix[pidx];
                    nxt_ms    = completes(pidx);
                    pidx++;
                end
                if (spur && $urandom_range(2, 0) == 0) cReady = 1'b1;
            end
            exp_ms   = nxt_ms;
            exp_done = nxt_done;
            if (ndone > 0) break;
            if (cyc > 3000) begin
                check("timeout", 1'b1, 1'b0);
                break;
            end
        end
        check("windows_issued", widx, NWIN);
        check("done_pulses", ndone, 1);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        do_reset();

        fill(1'b0, 1);
        run_frame(3, 3, 100, 1'b0, 0);
        run_frame(20, 20, 100, 1'b0, 0);
        run_frame(1, 5, 50, 1'b0, 0);

        run_frame(5, 5, 100, 1'b0, 2);
        do_reset();
        run_frame(2, 2, 100, 1'b0, 0);

        fill(1'b0, 101);
        run_frame(1, 1, 100, 1'b0, 0);

        fill(1'b1, 0);
        run_frame(1, 4, 70, 1'b1, 0);

        for (int f = 0; f < 3; f++) begin
            fill(1'b1, 0);
            run_frame(1, 6, 60, 1'(f % 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
